// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the unified-memory arbiter.
//   state_t    - arbiter FSM states (IDLE, READ, WRITE)
//   owner_t    - which requester owns the transaction in flight
//   BEATS      - byte beats per 32-bit word
//   LANE_W     - width of one byte lane
//   first_lane - lowest enabled lane index in a byte-enable mask
//   lane_byte  - extract byte lane k from a 32-bit word
//   clear_lane - drop lane k from a byte-enable mask
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam int BEATS  = 4;
    localparam int LANE_W = 8;

    // Scanning downwards leaves the lowest set lane as the final answer.
    function automatic logic [1:0] first_lane(input logic [BEATS-1:0] be);
        first_lane = 2'd0;
        for (int k = BEATS - 1; k >= 0; k--) begin
            if (be[k]) first_lane = 2'(k);
        end
    endfunction

    function automatic logic [LANE_W-1:0] lane_byte(input logic [31:0] word,
                                                    input logic [1:0]  k);
        lane_byte = word[LANE_W*k +: LANE_W];
    endfunction

    function automatic logic [BEATS-1:0] clear_lane(input logic [BEATS-1:0] be,
                                                    input logic [1:0]       k);
        clear_lane = be & ~(BEATS'(1) << k);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: combinational fixed-priority selector.
// Data port normally wins; once the data port has been granted STARVE_LIMIT
// times in a row while fetch waited, fetch is forced through.
//   i_req, d_req  - raw requests
//   starve_cnt    - consecutive data grants while fetch was pending
//   grant_i       - fetch would win if the arbiter is idle
//   grant_d       - data would win if the arbiter is idle
import mem_arb_pkg::*;

module mem_arb_prio #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_i,
    output logic             grant_d
);

    logic starved;

    assign starved = i_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_d = d_req && !starved;
    assign grant_i = i_req && !grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous memory between the fetch
// port and the load/store port. Each 32-bit request is serialised into
// little-endian byte beats at addr+0..addr+3 (wrapping in ADDR_W bits).
//   clk, rst_n                  - clock, async active-low reset
//   i_req/i_addr/i_gnt          - fetch request handshake
//   i_rvalid/i_rdata            - fetch response pulse and word
//   d_req/d_we/d_be/d_addr/d_wdata/d_gnt - load/store request handshake
//   d_rvalid/d_rdata            - load data / store-complete pulse
//   m_en/m_we/m_addr/m_wdata    - registered memory command
//   m_rdata                     - read byte, one cycle after a read beat
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t             state;
    owner_t             owner;
    logic [ADDR_W-1:0]  base;
    logic [BEATS-1:0]   be_rem;
    logic [31:0]        wdata;
    logic [2:0]         beat;
    logic [23:0]        rbuf;
    logic [CNT_W-1:0]   starve_cnt;
    logic               grant_i;
    logic               grant_d;
    logic [1:0]         acc_lane;
    logic [1:0]         next_lane;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // Grants exist only while idle; gating with rst_n keeps them low in reset.
    assign i_gnt = rst_n && (state == IDLE) && grant_i;
    assign d_gnt = rst_n && (state == IDLE) && grant_d;

    assign acc_lane  = first_lane(d_be);
    assign next_lane = first_lane(be_rem);

    // Starvation counter: counts data wins while fetch waits, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Beat sequencer and byte assembler. In READ, 'beat' equals the number of
    // edges since acceptance: beats 1..3 issue addr+beat, bytes come back two
    // edges after their beat, and the last byte is merged straight from
    // m_rdata at beat 5. In WRITE, be_rem holds lanes still to be written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= OWN_I;
            base     <= '0;
            be_rem   <= '0;
            wdata    <= '0;
            beat     <= '0;
            rbuf     <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    m_en <= 1'b0;
                    m_we <= 1'b0;
                    if (i_gnt || d_gnt) begin
                        owner <= i_gnt ? OWN_I : OWN_D;
                        base  <= i_gnt ? i_addr[ADDR_W-1:0] : d_addr[ADDR_W-1:0];
                        wdata <= d_wdata;
                        beat  <= 3'd1;
                        if (d_gnt && d_we) begin
                            state <= WRITE;
                            if (d_be != '0) begin
                                m_en    <= 1'b1;
                                m_we    <= 1'b1;
                                m_addr  <= d_addr[ADDR_W-1:0] + ADDR_W'(acc_lane);
                                m_wdata <= lane_byte(d_wdata, acc_lane);
                                be_rem  <= clear_lane(d_be, acc_lane);
                            end else begin
                                be_rem  <= '0;
                            end
                        end else begin
                            state  <= READ;
                            m_en   <= 1'b1;
                            m_addr <= i_gnt ? i_addr[ADDR_W-1:0] : d_addr[ADDR_W-1:0];
                        end
                    end
                end
                READ: begin
                    beat <= beat + 3'd1;
                    if (beat <= 3'd3) begin
                        m_addr <= base + ADDR_W'(beat);
                    end else begin
                        m_en <= 1'b0;
                    end
                    case (beat)
                        3'd2: rbuf[7:0]   <= m_rdata;
                        3'd3: rbuf[15:8]  <= m_rdata;
                        3'd4: rbuf[23:16] <= m_rdata;
                        default: ;
                    endcase
                    if (beat == 3'd5) begin
                        state <= IDLE;
                        if (owner == OWN_I) begin
                            i_rdata  <= {m_rdata, rbuf};
                            i_rvalid <= 1'b1;
                        end else begin
                            d_rdata  <= {m_rdata, rbuf};
                            d_rvalid <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (be_rem != '0) begin
                        m_en    <= 1'b1;
                        m_we    <= 1'b1;
                        m_addr  <= base + ADDR_W'(next_lane);
                        m_wdata <= lane_byte(wdata, next_lane);
                        be_rem  <= clear_lane(be_rem, next_lane);
                    end else begin
                        m_en     <= 1'b0;
                        m_we     <= 1'b0;
                        d_rvalid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a 64 KiB synchronous
// byte memory. Expected responses are computed from a reference copy of the
// memory when a grant is observed and checked when the response pulses.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } beat_t;

    logic [7:0] mem    [0:65535];
    logic [7:0] refmem [0:65535];
    exp_t       iq[$];
    exp_t       dq[$];
    beat_t      mlog[$];
    bit         glog[$];
    int         gcyc[$];
    logic [31:0] d_hold;
    int         cyc;
    int         checks;
    int         errors;

    mem_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous-read byte memory seen by the DUT.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [15:0] b0, b1, b2, b3;
        b0 = a[15:0];
        b1 = b0 + 16'd1;
        b2 = b0 + 16'd2;
        b3 = b0 + 16'd3;
        return {refmem[b3], refmem[b2], refmem[b1], refmem[b0]};
    endfunction

    // Monitor: invariants, scoreboard push on grant, pop/compare on response.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (i_gnt && d_gnt) begin
                errors++;
                $display("[TB] FAIL gnt_exclusive: i_gnt=%b d_gnt=%b both high at cycle %0d", i_gnt, d_gnt, cyc);
            end
            checks++;
            if (m_we && !m_en) begin
                errors++;
                $display("[TB] FAIL we_without_en: m_we=%b m_en=%b at cycle %0d", m_we, m_en, cyc);
            end
            if (m_en) mlog.push_back('{m_we, m_addr, m_wdata});
            if (i_gnt) begin
                glog.push_back(1'b1);
                gcyc.push_back(cyc);
                iq.push_back('{ref_word(i_addr), cyc + 6});
            end
            if (d_gnt) begin
                glog.push_back(1'b0);
                gcyc.push_back(cyc);
                if (d_we) begin
                    int n;
                    logic [15:0] a;
                    n = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (d_be[k]) begin
                            a = d_addr[15:0] + 16'(k);
                            refmem[a] = d_wdata[8*k +: 8];
                            n++;
                        end
                    end
                    dq.push_back('{d_hold, cyc + 1 + ((n == 0) ? 1 : n)});
                end else begin
                    d_hold = ref_word(d_addr);
                    dq.push_back('{d_hold, cyc + 6});
                end
            end
            if (i_rvalid) begin
                if (iq.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL i_unexpected: i_rvalid=1 with nothing outstanding, cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = iq.pop_front();
                    checks++;
                    if (i_rdata !== e.data) begin
                        errors++;
                        $display("[TB] FAIL i_rdata: got %h expected %h", i_rdata, e.data);
                    end
                    checks++;
                    if (cyc !== e.due) begin
                        errors++;
                        $display("[TB] FAIL i_latency: response at cycle %0d expected %0d", cyc, e.due);
                    end
                end
            end else if (iq.size() > 0 && cyc > iq[0].due) begin
                checks++; errors++;
                $display("[TB] FAIL i_missing: no i_rvalid by cycle %0d, expected at %0d", cyc, iq[0].due);
                void'(iq.pop_front());
            end
            if (d_rvalid) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL d_unexpected: d_rvalid=1 with nothing outstanding, cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    checks++;
                    if (d_rdata !== e.data) begin
                        errors++;
                        $display("[TB] FAIL d_rdata: got %h expected %h", d_rdata, e.data);
                    end
                    checks++;
                    if (cyc !== e.due) begin
                        errors++;
                        $display("[TB] FAIL d_latency: response at cycle %0d expected %0d", cyc, e.due);
                    end
                end
            end else if (dq.size() > 0 && cyc > dq[0].due) begin
                checks++; errors++;
                $display("[TB] FAIL d_missing: no d_rvalid by cycle %0d, expected at %0d", cyc, dq[0].due);
                void'(dq.pop_front());
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        int t;
        @(posedge clk); #1;
        i_addr = a;
        i_req  = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (i_gnt) break;
        end
        if (t == 100) begin
            checks++; errors++;
            $display("[TB] FAIL fetch_grant: no i_gnt within 100 cycles for addr %h", a);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic data_access(input logic we, input logic [3:0] be,
                               input logic [31:0] a, input logic [31:0] wd);
        int t;
        @(posedge clk); #1;
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (d_gnt) break;
        end
        if (t == 100) begin
            checks++; errors++;
            $display("[TB] FAIL data_grant: no d_gnt within 100 cycles for addr %h", a);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (iq.size() == 0 && dq.size() == 0) break;
        end
        if (t == 200) begin
            checks++; errors++;
            $display("[TB] FAIL drain: responses outstanding i=%0d d=%0d", iq.size(), dq.size());
            iq.delete();
            dq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        #13;
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: {ig,dg,irv,drv,en,we}=%b expected 000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we});
        end
        checks++;
        if ({m_addr, m_wdata} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem_port: m_addr=%h m_wdata=%h expected 0", m_addr, m_wdata);
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: i_rdata=%h d_rdata=%h expected 0", i_rdata, d_rdata);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        logic [31:0] got;
        mlog.delete();
        fetch(32'h0000_0100);
        drain();
        checks++;
        if (mlog.size() != 4) begin
            errors++;
            $display("[TB] FAIL fetch_beats: %0d beats expected 4", mlog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mlog[k] !== {1'b0, 16'h0100 + 16'(k), mlog[k].data}) begin
                    errors++;
                    $display("[TB] FAIL fetch_addr%0d: we=%b addr=%h expected read of %h", k, mlog[k].we, mlog[k].addr, 16'h0100 + 16'(k));
                end
            end
        end
        got = i_rdata;
        checks++;
        if (got !== 32'hDF9B5713) begin
            errors++;
            $display("[TB] FAIL fetch_word: i_rdata=%h expected DF9B5713", got);
        end
    endtask

    task automatic test_store_load();
        mlog.delete();
        data_access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        drain();
        checks++;
        if (mlog.size() != 2) begin
            errors++;
            $display("[TB] FAIL store_beats: %0d beats expected 2", mlog.size());
        end else begin
            checks++;
            if (mlog[0] !== {1'b1, 16'h0020, 8'hDD}) begin
                errors++;
                $display("[TB] FAIL store_beat0: got %h expected %h", mlog[0], {1'b1, 16'h0020, 8'hDD});
            end
            checks++;
            if (mlog[1] !== {1'b1, 16'h0022, 8'hBB}) begin
                errors++;
                $display("[TB] FAIL store_beat1: got %h expected %h", mlog[1], {1'b1, 16'h0022, 8'hBB});
            end
        end
        data_access(1'b0, 4'b0000, 32'h20, 32'h0);
        drain();
        checks++;
        if ({d_rdata[23:16], d_rdata[7:0]} !== 16'hBBDD) begin
            errors++;
            $display("[TB] FAIL load_lanes: d_rdata=%h expected xxBBxxDD", d_rdata);
        end
    endtask

    task automatic test_starvation();
        int t;
        bit exp_order [10];
        glog.delete();
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        @(posedge clk); #1;
        i_addr = 32'h100;
        i_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        d_req  = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk); #1;
            if (glog.size() >= 10) break;
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
        drain();
        checks++;
        if (glog.size() != 10) begin
            errors++;
            $display("[TB] FAIL starve_count: %0d grants expected 10", glog.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (glog[k] !== exp_order[k]) begin
                    errors++;
                    $display("[TB] FAIL starve_order%0d: got %s expected %s", k, glog[k] ? "I" : "D", exp_order[k] ? "I" : "D");
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        gcyc.delete();
        @(posedge clk); #1;
        d_we   = 1'b0;
        d_addr = 32'h300;
        d_req  = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (gcyc.size() >= 2) break;
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        drain();
        checks++;
        if (gcyc.size() != 2 || gcyc[1] - gcyc[0] != 6) begin
            errors++;
            $display("[TB] FAIL back_to_back: %0d grants, spacing %0d expected 6", gcyc.size(), (gcyc.size() >= 2) ? gcyc[1] - gcyc[0] : -1);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [4];
        exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        mlog.delete();
        data_access(1'b0, 4'b1111, 32'h0000_FFFE, 32'h0);
        drain();
        checks++;
        if (mlog.size() != 4) begin
            errors++;
            $display("[TB] FAIL wrap_beats: %0d beats expected 4", mlog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mlog[k].addr !== exp_addr[k]) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr%0d: got %h expected %h", k, mlog[k].addr, exp_addr[k]);
                end
            end
        end
    endtask

    task automatic test_zero_enable();
        mlog.delete();
        data_access(1'b1, 4'b0000, 32'h40, 32'h12345678);
        drain();
        checks++;
        if (mlog.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_be_beats: %0d memory cycles expected 0", mlog.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int t;
        mlog.delete();
        @(posedge clk); #1;
        i_addr = 32'h100;
        i_req  = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (mlog.size() >= 3) break;
        end
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        iq.delete();
        dq.delete();
        d_hold = 32'h0;
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, m_addr, i_rdata, d_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: en=%b we=%b addr=%h irv=%b i_rdata=%h expected all 0", m_en, m_we, m_addr, i_rvalid, i_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        fetch(32'h0000_0100);
        drain();
        checks++;
        if (i_rdata !== 32'hDF9B5713) begin
            errors++;
            $display("[TB] FAIL post_reset_fetch: i_rdata=%h expected DF9B5713", i_rdata);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        d_hold  = 32'h0;
        m_rdata = 8'h0;
        i_addr  = 32'h0;
        d_we    = 1'b0;
        d_be    = 4'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        for (int a = 0; a < 65536; a++) begin
            mem[a]    = 8'($urandom);
            refmem[a] = mem[a];
        end
        mem[16'h100] = 8'h13; refmem[16'h100] = 8'h13;
        mem[16'h101] = 8'h57; refmem[16'h101] = 8'h57;
        mem[16'h102] = 8'h9B; refmem[16'h102] = 8'h9B;
        mem[16'h103] = 8'hDF; refmem[16'h103] = 8'hDF;

        test_reset();
        test_single_fetch();
        test_store_load();
        test_starvation();
        test_back_to_back();
        test_wrap();
        test_zero_enable();
        test_reset_mid_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
